// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and defaults for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SERVE_MEM = 2'b01,
    SERVE_IF  = 2'b10
  } arb_state_e;

  function automatic logic any_mem_req(input logic rd_req, input logic wr_req);
    return rd_req | wr_req;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the unified RAM.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              if_stall;
  logic              mem_stall;

  // Pipeline stages and RAM model side
  modport master (
    output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    input  if_rdata, if_ack, mem_rdata, mem_ack, ram_req, ram_we, ram_addr,
           ram_wdata, if_stall, mem_stall
  );

  // Arbiter side
  modport slave (
    input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
           ram_rdata, ram_ready,
    output if_rdata, if_ack, mem_rdata, mem_ack, ram_req, ram_we, ram_addr,
           ram_wdata, if_stall, mem_stall
  );

endinterface

// File: rtl/unified_mem_arbiter_perf_cnt.sv
// Free-running wrapping event counter, cleared only by the async reset.
module mem_arb_perf_cnt #(
  parameter int           W         = 32,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count qualifying cycles; natural wrap from all-ones to zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= RESET_VAL;
    end else if (inc) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified RAM arbiter between IF and MEM stages (MEM has priority).
// Optional stall-cycle counters enabled by UNIFIED_MEM_ARBITER_PERF_EN.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  output logic [31:0]          if_wait_cnt,
  output logic [31:0]          mem_wait_cnt,
`endif
  unified_mem_arbiter_if.slave bus
);

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic              load_mem_s;
  logic              load_if_s;
  logic              mem_any_s;
  logic              if_ack_s;
  logic              mem_ack_s;
  logic              ram_req_r;
  logic              ram_we_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic [DATA_W-1:0] ram_wdata_r;

  assign mem_any_s = any_mem_req(bus.mem_rd_req, bus.mem_wr_req);

  // Next grant: MEM first from IDLE; on completion hand over to the other requester
  always_comb begin
    state_s    = state_r;
    load_mem_s = 1'b0;
    load_if_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_any_s) begin
          state_s    = SERVE_MEM;
          load_mem_s = 1'b1;
        end else if (bus.if_req) begin
          state_s   = SERVE_IF;
          load_if_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SERVE_MEM: begin
        if (bus.ram_ready) begin
          if (bus.if_req) begin
            state_s   = SERVE_IF;
            load_if_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = SERVE_MEM;
        end
      end
      SERVE_IF: begin
        if (bus.ram_ready) begin
          if (mem_any_s) begin
            state_s    = SERVE_MEM;
            load_mem_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = SERVE_IF;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and RAM command; the command is held untouched between grants
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      ram_req_r   <= 1'b0;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      ram_req_r <= (state_s != IDLE);
      if (load_mem_s) begin
        ram_we_r    <= bus.mem_wr_req;
        ram_addr_r  <= bus.mem_addr;
        ram_wdata_r <= bus.mem_wdata;
      end else if (load_if_s) begin
        ram_we_r    <= 1'b0;
        ram_addr_r  <= bus.if_addr;
        ram_wdata_r <= {DATA_W{1'b0}};
      end else begin
        ram_we_r    <= ram_we_r;
        ram_addr_r  <= ram_addr_r;
        ram_wdata_r <= ram_wdata_r;
      end
    end
  end

  // Completion is combinational on ram_ready so the stage can advance the same cycle
  assign if_ack_s  = (state_r == SERVE_IF)  & bus.ram_ready;
  assign mem_ack_s = (state_r == SERVE_MEM) & bus.ram_ready;

  assign bus.if_ack    = if_ack_s;
  assign bus.mem_ack   = mem_ack_s;
  assign bus.if_rdata  = bus.ram_rdata;
  assign bus.mem_rdata = bus.ram_rdata;
  assign bus.if_stall  = bus.if_req & ~if_ack_s;
  assign bus.mem_stall = mem_any_s & ~mem_ack_s;
  assign bus.ram_req   = ram_req_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  mem_arb_perf_cnt #(.W(32)) u_if_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.if_stall),
    .count   (if_wait_cnt)
  );

  mem_arb_perf_cnt #(.W(32)) u_mem_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (bus.mem_stall),
    .count   (mem_wait_cnt)
  );
`else
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed table, corner sequences, random vs model.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
  logic [31:0] if_wait_cnt;
  logic [31:0] mem_wait_cnt;
  logic        wrap_inc = 1'b0;
  logic [31:0] wrap_count;

  mem_arb_perf_cnt #(.W(32), .RESET_VAL(32'hFFFF_FFFD)) u_wrap (
    .clk(clk), .reset_n(reset_n), .inc(wrap_inc), .count(wrap_count)
  );
`endif

  unified_mem_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    .if_wait_cnt  (if_wait_cnt),
    .mem_wait_cnt (mem_wait_cnt),
`endif
    .bus          (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Loads and stores are never requested together by a correct pipeline
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(bus.mem_rd_req && bus.mem_wr_req))
        else $error("illegal simultaneous load and store request");
    end
  end

  typedef struct {
    logic        if_req, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        e_if_ack, e_mem_ack, e_if_stall, e_mem_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic mr,
                              input logic mw, input logic [31:0] ma, input logic [31:0] wd,
                              input logic rdy, input logic [31:0] rd,
                              input logic eia, input logic ema, input logic eis,
                              input logic ems, input logic erq, input logic ewe,
                              input logic [31:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.mem_rd = mr; v.mem_wr = mw; v.mem_addr = ma;
    v.wdata = wd; v.ready = rdy; v.rdata = rd;
    v.e_if_ack = eia; v.e_mem_ack = ema; v.e_if_stall = eis; v.e_mem_stall = ems;
    v.e_req = erq; v.e_we = ewe; v.e_addr = ea; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                       input logic [31:0] ma, input logic [31:0] wd, input logic rdy,
                       input logic [31:0] rd);
    bus.if_req = ir; bus.if_addr = ia; bus.mem_rd_req = mr; bus.mem_wr_req = mw;
    bus.mem_addr = ma; bus.mem_wdata = wd; bus.ram_ready = rdy; bus.ram_rdata = rd;
  endtask

  vec_t vecs[14];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_if_cnt;
    int exp_mem_cnt;
    // reference model: who holds the RAM and the command it was granted
    int          m_serv;      // 0 none, 1 MEM, 2 IF
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic        if_pend, mem_pend, mem_is_wr;
    logic        e_if_ack, e_mem_ack, e_if_stall, e_mem_stall;
    logic        mem_any;

    localparam logic [31:0] A  = 32'h0040_0000;
    localparam logic [31:0] A4 = 32'h0040_0004;
    localparam logic [31:0] M  = 32'h1001_0000;
    localparam logic [31:0] S  = 32'h1001_0008;
    localparam logic [31:0] D  = 32'hDEAD_BEEF;

    vecs[0]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[1]  = mk(1'b1, A,     1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8C22_0004,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[2]  = mk(1'b1, A,     1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h8C22_0004,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, A,     32'd0);
    vecs[3]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[4]  = mk(1'b1, A4,    1'b1, 1'b0, M,     32'd0, 1'b1, 32'h1111_1111,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[5]  = mk(1'b1, A4,    1'b1, 1'b0, M,     32'd0, 1'b1, 32'h2222_2222,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, M,     32'd0);
    vecs[6]  = mk(1'b1, A4,    1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h3333_3333,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, A4,    32'd0);
    vecs[7]  = mk(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[8]  = mk(1'b0, 32'd0, 1'b0, 1'b1, S,     D,     1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    vecs[9]  = mk(1'b0, 32'd0, 1'b0, 1'b1, S,     D,     1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S,     D);
    vecs[10] = mk(1'b0, 32'd0, 1'b0, 1'b1, S,     D,     1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S,     D);
    vecs[11] = mk(1'b0, 32'd0, 1'b0, 1'b1, S,     D,     1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S,     D);
    vecs[12] = mk(1'b0, 32'd0, 1'b0, 1'b1, S,     D,     1'b1, 32'h0BAD_F00D,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, S,     D);
    vecs[13] = mk(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset held with a fetch pending and the RAM claiming ready
    reset_n = 1'b0;
    drive(1'b1, A, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h1234_5678);
    repeat (2) @(negedge clk);
    #1;
    check("rst_ram_req",   {31'd0, bus.ram_req},  32'd0);
    check("rst_ram_we",    {31'd0, bus.ram_we},   32'd0);
    check("rst_ram_addr",  bus.ram_addr,          32'd0);
    check("rst_ram_wdata", bus.ram_wdata,         32'd0);
    check("rst_if_ack",    {31'd0, bus.if_ack},   32'd0);
    check("rst_mem_ack",   {31'd0, bus.mem_ack},  32'd0);
    check("rst_if_stall",  {31'd0, bus.if_stall}, 32'd1);
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    check("rst_if_cnt",    if_wait_cnt,           32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("rel_ram_req",  {31'd0, bus.ram_req}, 32'd1);
    check("rel_ram_addr", bus.ram_addr,         A);
    check("rel_if_ack",   {31'd0, bus.if_ack},  32'd1);

    // Directed table: zero-wait fetch, MEM/IF conflict, store with three wait cycles
    exp_if_cnt  = 1;
    exp_mem_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].if_req, vecs[i].if_addr, vecs[i].mem_rd, vecs[i].mem_wr,
            vecs[i].mem_addr, vecs[i].wdata, vecs[i].ready, vecs[i].rdata);
      #1;
      check($sformatf("v%0d_if_ack", i),    {31'd0, bus.if_ack},    {31'd0, vecs[i].e_if_ack});
      check($sformatf("v%0d_mem_ack", i),   {31'd0, bus.mem_ack},   {31'd0, vecs[i].e_mem_ack});
      check($sformatf("v%0d_if_stall", i),  {31'd0, bus.if_stall},  {31'd0, vecs[i].e_if_stall});
      check($sformatf("v%0d_mem_stall", i), {31'd0, bus.mem_stall}, {31'd0, vecs[i].e_mem_stall});
      check($sformatf("v%0d_ram_req", i),   {31'd0, bus.ram_req},   {31'd0, vecs[i].e_req});
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_ram_we", i),    {31'd0, bus.ram_we}, {31'd0, vecs[i].e_we});
        check($sformatf("v%0d_ram_addr", i),  bus.ram_addr,        vecs[i].e_addr);
        check($sformatf("v%0d_ram_wdata", i), bus.ram_wdata,       vecs[i].e_wdata);
      end
      if (vecs[i].e_if_ack)  check($sformatf("v%0d_if_rdata", i),  bus.if_rdata,  vecs[i].rdata);
      if (vecs[i].e_mem_ack) check($sformatf("v%0d_mem_rdata", i), bus.mem_rdata, vecs[i].rdata);
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
      check($sformatf("v%0d_if_cnt", i),  if_wait_cnt,  exp_if_cnt);
      check($sformatf("v%0d_mem_cnt", i), mem_wait_cnt, exp_mem_cnt);
`endif
      exp_if_cnt  += int'(vecs[i].e_if_stall);
      exp_mem_cnt += int'(vecs[i].e_mem_stall);
    end
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    // store phase alone: 4 stall cycles on top of the single conflict-cycle stall
    check("store_mem_cnt", mem_wait_cnt, 32'd5);
`endif

    // Reset asserted while a load is waiting on the RAM
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 32'h1001_0010, 32'd0, 1'b0, 32'd0);
    #1;
    check("mid_idle_req", {31'd0, bus.ram_req}, 32'd0);
    @(negedge clk);
    #1;
    check("mid_serve_req", {31'd0, bus.ram_req}, 32'd1);
    #2;
    reset_n = 1'b0;
    bus.ram_ready = 1'b1;
    #1;
    check("mid_rst_req",   {31'd0, bus.ram_req},   32'd0);
    check("mid_rst_ack",   {31'd0, bus.mem_ack},   32'd0);
    check("mid_rst_stall", {31'd0, bus.mem_stall}, 32'd1);
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    check("mid_rst_cnt", mem_wait_cnt, 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    reset_n = 1'b1;
    #1;
    check("mid_rel_ack", {31'd0, bus.mem_ack}, 32'd0);
    @(negedge clk);
    #1;
    check("mid_rel_req", {31'd0, bus.ram_req}, 32'd0);
    check("mid_rel_ack2", {31'd0, bus.mem_ack}, 32'd0);

    // Randomised traffic against the grant-rule model
    m_serv = 0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'd0;
    if_pend = 1'b0; mem_pend = 1'b0; mem_is_wr = 1'b0;
    exp_if_cnt = 0; exp_mem_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!if_pend && ($urandom_range(0, 2) == 0)) begin
        if_pend = 1'b1;
        bus.if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
      end
      if (!mem_pend && ($urandom_range(0, 2) == 0)) begin
        mem_pend = 1'b1;
        mem_is_wr = 1'($urandom_range(0, 1));
        bus.mem_addr = $urandom;
        bus.mem_wdata = $urandom;
      end
      bus.if_req     = if_pend;
      bus.mem_rd_req = mem_pend & ~mem_is_wr;
      bus.mem_wr_req = mem_pend & mem_is_wr;
      bus.ram_ready  = ($urandom_range(0, 3) != 0);
      bus.ram_rdata  = $urandom;
      #1;
      mem_any     = mem_pend;
      e_if_ack    = (m_serv == 2) && bus.ram_ready;
      e_mem_ack   = (m_serv == 1) && bus.ram_ready;
      e_if_stall  = if_pend && !e_if_ack;
      e_mem_stall = mem_any && !e_mem_ack;
      check("rnd_if_ack",    {31'd0, bus.if_ack},    {31'd0, e_if_ack});
      check("rnd_mem_ack",   {31'd0, bus.mem_ack},   {31'd0, e_mem_ack});
      check("rnd_if_stall",  {31'd0, bus.if_stall},  {31'd0, e_if_stall});
      check("rnd_mem_stall", {31'd0, bus.mem_stall}, {31'd0, e_mem_stall});
      check("rnd_ram_req",   {31'd0, bus.ram_req},   (m_serv != 0) ? 32'd1 : 32'd0);
      if (m_serv != 0) begin
        check("rnd_ram_we",    {31'd0, bus.ram_we}, {31'd0, m_we});
        check("rnd_ram_addr",  bus.ram_addr,        m_addr);
        check("rnd_ram_wdata", bus.ram_wdata,       m_wdata);
      end
      if (e_if_ack)  check("rnd_if_rdata",  bus.if_rdata,  bus.ram_rdata);
      if (e_mem_ack) check("rnd_mem_rdata", bus.mem_rdata, bus.ram_rdata);
`ifdef UNIFIED_MEM_ARBITER_PERF_EN
      check("rnd_if_cnt",  if_wait_cnt,  exp_if_cnt);
      check("rnd_mem_cnt", mem_wait_cnt, exp_mem_cnt);
`endif
      exp_if_cnt  += int'(e_if_stall);
      exp_mem_cnt += int'(e_mem_stall);
      // RAM free now or after this completion: MEM first, never re-grant the one just served
      if (m_serv == 0 || bus.ram_ready) begin
        if (mem_any && m_serv != 1) begin
          m_we = mem_is_wr; m_addr = bus.mem_addr; m_wdata = bus.mem_wdata;
          m_serv = 1;
        end else if (if_pend && m_serv != 2) begin
          m_we = 1'b0; m_addr = bus.if_addr; m_wdata = 32'd0;
          m_serv = 2;
        end else begin
          m_serv = 0;
        end
      end
      if (e_if_ack)  if_pend  = 1'b0;
      if (e_mem_ack) mem_pend = 1'b0;
    end

`ifdef UNIFIED_MEM_ARBITER_PERF_EN
    // Counter wrap from a value preloaded just below all-ones
    @(negedge clk);
    check("wrap_start", wrap_count, 32'hFFFF_FFFD);
    wrap_inc = 1'b1;
    repeat (2) @(negedge clk);
    check("wrap_max", wrap_count, 32'hFFFF_FFFF);
    @(negedge clk);
    check("wrap_zero", wrap_count, 32'd0);
    wrap_inc = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
